// File: rtl/hb_pkg.sv
// Shared types and constants for the halfband decimator front end:
// 31-tap halfband coefficients (non-zero taps only), tap offsets and FSM states.
package hb_pkg;

   localparam int DATA_W   = 16;
   localparam int COEF_W   = 16;
   localparam int HB_NTAPS = 31;
   localparam int HB_NNZ   = 17;

   typedef logic signed [COEF_W-1:0] coef_t;

   // Even taps j = 0,2,..,14 then centre j = 15 then j = 16,..,30; symmetric about index 8
   localparam coef_t COEFF [0:HB_NNZ-1] = '{
      -16'sd12,  16'sd20,  -16'sd38,  16'sd66, -16'sd110, 16'sd180, -16'sd310, 16'sd1020,
       16'sd2048,
       16'sd1020, -16'sd310, 16'sd180, -16'sd110, 16'sd66, -16'sd38, 16'sd20, -16'sd12
   };

   localparam logic [4:0] TAP_OFS [0:HB_NNZ-1] = '{
      5'd0,  5'd2,  5'd4,  5'd6,  5'd8,  5'd10, 5'd12, 5'd14,
      5'd15,
      5'd16, 5'd18, 5'd20, 5'd22, 5'd24, 5'd26, 5'd28, 5'd30
   };

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      TAPS    = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4
   } state_t;

endpackage

// File: rtl/hb_dec_sequencer_if.sv
// Sample stream in/out plus the control/data bus towards the MAC unit.
interface hb_dec_sequencer_if;
   import hb_pkg::*;

   logic                       strobe_in;
   logic signed [DATA_W-1:0]   data_in;
   logic                       mac_enable;
   logic                       mac_clear;
   logic signed [DATA_W-1:0]   mac_x;
   logic signed [COEF_W-1:0]   mac_y;
   logic [7:0]                 mac_shift;
   logic signed [DATA_W-1:0]   mac_z;
   logic                       strobe_out;
   logic signed [DATA_W-1:0]   data_out;
   logic                       busy;
   logic                       overrun;

   modport master (
      input  strobe_in, data_in, mac_z,
      output mac_enable, mac_clear, mac_x, mac_y, mac_shift,
             strobe_out, data_out, busy, overrun
   );

   modport slave (
      output strobe_in, data_in, mac_z,
      input  mac_enable, mac_clear, mac_x, mac_y, mac_shift,
             strobe_out, data_out, busy, overrun
   );

endinterface

// File: rtl/hb_dec_sequencer_sample_buf.sv
// 32-entry circular sample store: zeroed on reset, written at wr_ptr, read combinationally.
module hb_sample_buf
   import hb_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic signed [DATA_W-1:0] wr_data,
   input  logic [4:0]               rd_addr,
   output logic signed [DATA_W-1:0] rd_data,
   output logic [4:0]               wr_ptr
);

   logic signed [DATA_W-1:0] mem [0:31];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         wr_ptr <= 5'd0;
      end else if (wr_en) begin
         mem[wr_ptr] <= wr_data;
         wr_ptr      <= wr_ptr + 5'd1;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hb_dec_sequencer.sv
// Halfband decimator sequencer: buffers samples, feeds 17 tap pairs to the MAC
// on every second input, and captures one decimated output per two inputs.
module hb_dec_sequencer
   import hb_pkg::*;
#(
   parameter logic [7:0] SHIFT = 8'd8,
   parameter int         NTAPS = 31
) (
   input logic          clock,
   input logic          reset,
   hb_dec_sequencer_if.master bus
);

   if (NTAPS != HB_NTAPS) begin : g_ntaps_check
      $error("hb_dec_sequencer supports only a 31-tap halfband");
   end

   state_t                   state;
   logic [4:0]               k;
   logic [4:0]               base;
   logic                     phase;
   logic                     drain_cnt;
   logic                     mac_clear_r;
   logic                     mac_enable_r;
   logic                     strobe_out_r;
   logic                     busy_r;
   logic                     overrun_r;
   logic signed [DATA_W-1:0] data_out_r;
   logic                     start;
   logic [4:0]               wr_ptr;
   logic [4:0]               rd_addr;
   logic signed [DATA_W-1:0] rd_data;

   assign start   = bus.strobe_in & phase;
   // base points one past the newest sample of the window
   assign rd_addr = base - 5'd1 - TAP_OFS[k];

   hb_sample_buf u_buf (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (bus.strobe_in),
      .wr_data (bus.data_in),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_ptr  (wr_ptr)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         k            <= 5'd0;
         base         <= 5'd0;
         phase        <= 1'b0;
         drain_cnt    <= 1'b0;
         mac_clear_r  <= 1'b0;
         mac_enable_r <= 1'b0;
         strobe_out_r <= 1'b0;
         busy_r       <= 1'b0;
         overrun_r    <= 1'b0;
         data_out_r   <= '0;
      end else begin
         strobe_out_r <= 1'b0;
         if (bus.strobe_in) phase <= ~phase;
         if (start && state != IDLE) overrun_r <= 1'b1;
         unique case (state)
            IDLE: if (start) begin
               base        <= wr_ptr + 5'd1;
               mac_clear_r <= 1'b1;
               busy_r      <= 1'b1;
               state       <= CLEAR;
            end
            CLEAR: begin
               mac_clear_r  <= 1'b0;
               mac_enable_r <= 1'b1;
               k            <= 5'd0;
               state        <= TAPS;
            end
            TAPS: if (k == 5'(HB_NNZ - 1)) begin
               mac_enable_r <= 1'b0;
               drain_cnt    <= 1'b0;
               k            <= 5'd0;
               state        <= DRAIN;
            end else begin
               k <= k + 5'd1;
            end
            // Two idle cycles let the MAC's product register and delayed enable settle
            DRAIN: begin
               drain_cnt <= ~drain_cnt;
               if (drain_cnt) state <= CAPTURE;
            end
            CAPTURE: begin
               data_out_r   <= bus.mac_z;
               strobe_out_r <= 1'b1;
               busy_r       <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mac_clear  = mac_clear_r;
   assign bus.mac_enable = mac_enable_r;
   assign bus.mac_x      = mac_enable_r ? rd_data : '0;
   assign bus.mac_y      = mac_enable_r ? COEFF[k] : '0;
   assign bus.mac_shift  = SHIFT;
   assign bus.strobe_out = strobe_out_r;
   assign bus.data_out   = data_out_r;
   assign bus.busy       = busy_r;
   assign bus.overrun    = overrun_r;

endmodule
